// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//
// Turns the per-neuron spike levels of a LIF neuron bank into a stream of
// address-event (AER) words. Each neuron owns a pending flag. A round-robin
// arbiter moves one pending neuron per cycle into a first-word-fall-through
// FIFO. The FIFO head drives the output stream.
//
// Optional feature macro: AER_TIMESTAMP_EN
//   defined   : a free-running TS_W counter is stamped into every FIFO entry
//               and presented on aer_ts.
//   undefined : no counter, no timestamp storage, aer_ts is tied to 0.
//
// Ports
//   clk         in   1          sole clock, rising edge
//   rst         in   1          asynchronous, active-high reset
//   spike_in    in   N_NEURONS  one bit per neuron, high level = one event
//   aer_valid   out  1          an event word is presented (FIFO not empty)
//   aer_ready   in   1          consumer accepts the presented word
//   aer_addr    out  ADDR_W     index of the spiking neuron (head entry)
//   aer_ts      out  TS_W       push-time timestamp of the head entry
//   drop_count  out  DROP_W     saturating count of merged (lost) events
//   fifo_full   out  1          FIFO occupancy equals FIFO_DEPTH
//
// Stream handshake: a word transfers on every rising edge where aer_valid
// and aer_ready are both high. aer_valid never depends on aer_ready, and
// once raised it stays high with aer_addr/aer_ts stable until the transfer.
// All outputs come straight from registers (no input-to-output paths).

module spike_aer_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16,
  parameter int DROP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 fifo_full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(N_NEURONS + 1);
  localparam int SAT_W = ((DROP_W > SUM_W) ? DROP_W : SUM_W) + 1;

  localparam logic [ADDR_W-1:0] LAST_RST = ADDR_W'(N_NEURONS - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [N_NEURONS-1:0] pend;
  logic [ADDR_W-1:0]    last_grant;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [ADDR_W-1:0]    mem_addr [FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------
  logic                 grant_found;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 pop;
  logic                 grant;
  logic [N_NEURONS-1:0] grant_mask;

  // Round-robin in two passes: indices above last_grant first, then the
  // wrapped range 0..last_grant. The first pending hit in that order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (!grant_found && pend[i] && (ADDR_W'(i) > last_grant)) begin
        grant_found = 1'b1;
        grant_idx   = ADDR_W'(i);
      end
    end
    for (int i = 0; i < N_NEURONS; i++) begin
      if (!grant_found && pend[i] && (ADDR_W'(i) <= last_grant)) begin
        grant_found = 1'b1;
        grant_idx   = ADDR_W'(i);
      end
    end
  end

  assign pop   = aer_valid & aer_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign grant = grant_found & (~fifo_full | pop);

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      grant_mask[i] = grant && (grant_idx == ADDR_W'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Pending flags and drop accounting
  // ---------------------------------------------------------------------
  logic [N_NEURONS-1:0] pend_next;
  logic [N_NEURONS-1:0] drop_vec;
  logic [SUM_W-1:0]     drop_sum;
  logic [SAT_W-1:0]     drop_ext;
  logic [DROP_W-1:0]    drop_next;

  // A spike on the granted neuron re-arms its flag as a fresh event; a
  // spike on a still-pending, non-granted neuron merges and is lost.
  assign pend_next = spike_in | (pend & ~grant_mask);
  assign drop_vec  = spike_in & pend & ~grant_mask;

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
  end

  assign drop_ext  = SAT_W'(drop_count) + SAT_W'(drop_sum);
  assign drop_next = (drop_ext > SAT_W'(DROP_MAX)) ? DROP_MAX : drop_ext[DROP_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      last_grant <= LAST_RST;
      drop_count <= '0;
    end else begin
      pend       <= pend_next;
      drop_count <= drop_next;
      if (grant) begin
        last_grant <= grant_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem_addr[wr_ptr] <= grant_idx;
    end
  end

  assign aer_valid = (count != '0);
  assign fifo_full = (count == CNT_FULL);
  assign aer_addr  = aer_valid ? mem_addr[rd_ptr] : '0;

  // ---------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------
`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // The stamp is the counter value seen on the push edge.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem_ts[wr_ptr] <= ts_cnt;
    end
  end

  assign aer_ts = aer_valid ? mem_ts[rd_ptr] : '0;
`else
  assign aer_ts = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: default parameters
  logic [15:0] spike_in  = '0;
  logic        aer_ready = 1'b0;
  logic        aer_valid;
  logic [3:0]  aer_addr;
  logic [15:0] aer_ts;
  logic [7:0]  drop_count;
  logic        fifo_full;

  // Small instance: DROP_W=2, TS_W=4 for saturation and wrap
  logic [15:0] spike_s = '0;
  logic        ready_s = 1'b0;
  logic        valid_s;
  logic [3:0]  addr_s;
  logic [3:0]  ts_s;
  logic [1:0]  drop_s;
  logic        full_s;

  spike_aer_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .drop_count (drop_count),
    .fifo_full  (fifo_full)
  );

  spike_aer_encoder #(.TS_W(4), .DROP_W(2)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_s),
    .aer_valid  (valid_s),
    .aer_ready  (ready_s),
    .aer_addr   (addr_s),
    .aer_ts     (ts_s),
    .drop_count (drop_s),
    .fifo_full  (full_s)
  );

  // Edges since reset release; equals the DUT timestamp counter value
  // when read #1 after an edge.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_cmp   = 0;
  int n_fail  = 0;
  int n_words = 0;
  int model_last = 15;
  int exp_drops  = 0;
  logic [19:0] exp_q[$];    // {addr, ts}
  logic [7:0]  exp_q_s[$];  // {addr, ts}
  logic [19:0] e_main;
  logic [7:0]  e_small;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int addr, input int ts);
`ifdef AER_TIMESTAMP_EN
    exp_q.push_back({4'(addr), 16'(ts)});
`else
    exp_q.push_back({4'(addr), 16'h0});
`endif
  endtask

  task automatic push_exp_s(input int addr, input int ts);
`ifdef AER_TIMESTAMP_EN
    exp_q_s.push_back({4'(addr), 4'(ts)});
`else
    exp_q_s.push_back({4'(addr), 4'h0});
`endif
  endtask

  // Expected words of a one-cycle pulse into an idle block with ready high:
  // round-robin order from model_last+1, one push per edge starting one
  // edge after the sample edge.
  task automatic push_rr(input logic [15:0] s, input int c0);
    int j;
    int idx;
    int last;
    j = 0;
    last = model_last;
    for (int off = 1; off <= 16; off++) begin
      idx = (model_last + off) % 16;
      if (s[idx]) begin
        push_exp(idx, c0 + 1 + j);
        j++;
        last = idx;
      end
    end
    model_last = last;
  endtask

  always @(negedge clk) begin
    if (!rst && aer_valid && aer_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got addr %0d ts %0d, expected no word", aer_addr, aer_ts);
      end else begin
        e_main = exp_q.pop_front();
        check("word_addr", 32'(aer_addr), 32'(e_main[19:16]));
        check("word_ts", 32'(aer_ts), 32'(e_main[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_s && ready_s) begin
      if (exp_q_s.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word_s: got addr %0d ts %0d, expected no word", addr_s, ts_s);
      end else begin
        e_small = exp_q_s.pop_front();
        check("word_addr_s", 32'(addr_s), 32'(e_small[7:4]));
        check("word_ts_s", 32'(ts_s), 32'(e_small[3:0]));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || aer_valid) && k < max) begin
      step();
      k++;
    end
    check(name, 32'(exp_q.size() == 0 && !aer_valid), 32'd1);
  endtask

  task automatic wait_drain_s(input string name, input int max);
    int k;
    k = 0;
    while ((exp_q_s.size() != 0 || valid_s) && k < max) begin
      step();
      k++;
    end
    check(name, 32'(exp_q_s.size() == 0 && !valid_s), 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [15:0] spikes;
    int          exp_words;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] r;
  int w0;
  int c0;
  int c1;
  int k;
  int sat_exp[6];

  initial begin
    vecs[0] = '{16'hFFFF, 16};
    vecs[1] = '{16'h8001, 2};
    vecs[2] = '{16'h0410, 2};
    vecs[3] = '{16'h00F0, 4};
    vecs[4] = '{16'hAAAA, 8};
    for (int v = 5; v < 8; v++) begin
      r = 16'($urandom_range(1, 65535));
      vecs[v] = '{r, $countones(r)};
    end
    sat_exp = '{0, 1, 2, 3, 3, 3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(aer_valid), 0);
    check("rst_addr", 32'(aer_addr), 0);
    check("rst_ts", 32'(aer_ts), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_valid_s", 32'(valid_s), 0);
    @(negedge clk);
    rst = 1'b0;
    step();  // cyc = 1

    // Table: one-cycle pulses into an idle block, ready held high
    aer_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      w0 = n_words;
      push_rr(vecs[v].spikes, cyc);
      spike_in = vecs[v].spikes;
      step();
      spike_in = '0;
      wait_drain("vec_drain", 60);
      check("vec_words", 32'(n_words - w0), 32'(vecs[v].exp_words));
      check("vec_drops", 32'(drop_count), 32'(exp_drops));
    end

    // Fairness: grant 3 once, then hold 3 and 5 for six edges
    c0 = cyc;
    push_exp(3, c0 + 1);
    for (int j = 1; j <= 7; j++) push_exp((j % 2 == 1) ? 5 : 3, c0 + 2 + j);
    spike_in = 16'h0008;
    step();
    spike_in = '0;
    step();
    spike_in = 16'h0028;
    repeat (6) step();
    spike_in = '0;
    exp_drops += 5;
    model_last = 5;
    wait_drain("fair_drain", 40);
    check("fair_drops", 32'(drop_count), 32'(exp_drops));

    // Park last_grant at 15 so the burst below starts at neuron 0
    push_rr(16'h8000, cyc);
    spike_in = 16'h8000;
    step();
    spike_in = '0;
    wait_drain("park_drain", 20);

    // Backpressure: neurons 0..9 pulsed twice, 20 edges apart, ready low
    aer_ready = 1'b0;
    c0 = cyc;
    for (int j = 0; j < 8; j++) push_exp(j, c0 + 1 + j);
    spike_in = 16'h03FF;
    step();
    spike_in = '0;
    repeat (7) step();
    check("bp_not_full_7", 32'(fifo_full), 0);
    step();
    check("bp_full_8", 32'(fifo_full), 1);
    check("bp_valid", 32'(aer_valid), 1);
    check("bp_head", 32'(aer_addr), 0);
    repeat (11) step();
    spike_in = 16'h03FF;
    step();
    spike_in = '0;
    exp_drops += 2;
    check("bp_drops", 32'(drop_count), 32'(exp_drops));
    check("bp_still_full", 32'(fifo_full), 1);
    check("bp_head_held", 32'(aer_addr), 0);
    c1 = cyc;
    push_exp(8, c1);
    push_exp(9, c1 + 1);
    for (int j = 0; j < 8; j++) push_exp(j, c1 + 2 + j);
    model_last = 7;
    aer_ready = 1'b1;
    wait_drain("bp_drain", 60);
    check("bp_drops_after", 32'(drop_count), 32'(exp_drops));

    // Timestamp wrap on the TS_W=4 instance
    ready_s = 1'b1;
    k = 0;
    while ((cyc % 16) != 14 && k < 20) begin
      step();
      k++;
    end
    push_exp_s(4, 15);
    push_exp_s(4, 0);
    spike_s = 16'h0010;
    repeat (2) step();
    spike_s = '0;
    wait_drain_s("wrap_drain", 20);

    // Drop saturation on the DROP_W=2 instance: 5 drops -> 3
    ready_s = 1'b0;
    spike_s = 16'h0003;
    for (int j = 0; j < 6; j++) begin
      step();
      check("sat_drop", 32'(drop_s), 32'(sat_exp[j]));
    end
    spike_s = '0;
    check("sat_not_full", 32'(full_s), 0);

    // Reset mid-stream with 4 words queued
    aer_ready = 1'b0;
    spike_in = 16'h000F;
    step();
    spike_in = '0;
    repeat (4) step();
    check("mid_valid", 32'(aer_valid), 1);
    check("mid_drops", 32'(drop_count), 32'(exp_drops));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(aer_valid), 0);
    check("arst_addr", 32'(aer_addr), 0);
    check("arst_ts", 32'(aer_ts), 0);
    check("arst_drop", 32'(drop_count), 0);
    check("arst_full", 32'(fifo_full), 0);
    check("arst_drop_s", 32'(drop_s), 0);
    check("arst_valid_s", 32'(valid_s), 0);
    exp_q.delete();
    exp_q_s.delete();
    model_last = 15;
    exp_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    aer_ready = 1'b1;
    ready_s = 1'b1;
    repeat (8) step();
    check("post_rst_idle", 32'(aer_valid), 0);
    check("post_rst_idle_s", 32'(valid_s), 0);

    // Single spike latency: valid high for exactly one cycle, 2 after sample
    c0 = cyc;
    push_exp(0, c0 + 1);
    spike_in = 16'h0001;
    step();
    check("single_lat1", 32'(aer_valid), 0);
    spike_in = '0;
    step();
    check("single_lat2", 32'(aer_valid), 1);
    check("single_addr", 32'(aer_addr), 0);
    step();
    check("single_lat3", 32'(aer_valid), 0);
    wait_drain("single_drain", 10);
    check("final_drops", 32'(drop_count), 0);
    check("final_q_s", 32'(exp_q_s.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
